// File: rtl/alu_op_issuer_if.sv
// Command/response channels between a requester and alu_op_issuer.
// ALU_ZCHECK_EN adds rsp_err to the response channel.
interface alu_op_issuer_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned TAG_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_opcode;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic [4:0]       cmd_shift;
  logic [TAG_W-1:0] cmd_tag;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic [2:0]       rsp_flags;
  logic [TAG_W-1:0] rsp_tag;
`ifdef ALU_ZCHECK_EN
  logic             rsp_err;
`endif

  modport master (
    output cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_shift, cmd_tag, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_result, rsp_flags, rsp_tag
`ifdef ALU_ZCHECK_EN
    , rsp_err
`endif
  );

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_shift, cmd_tag, rsp_ready,
    output cmd_ready, rsp_valid, rsp_result, rsp_flags, rsp_tag
`ifdef ALU_ZCHECK_EN
    , rsp_err
`endif
  );
endinterface

// File: rtl/alu_op_issuer.sv
// Queues ALU commands, drives an attached combinational ALU, samples it after SETTLE
// cycles and returns result/flags/tag in order. ALU_ZCHECK_EN adds rsp_err.
module alu_op_issuer #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned SETTLE = 1,
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_op_issuer_if.slave    bus,
  output logic [3:0]        opcode,
  output logic [WIDTH-1:0]  input1,
  output logic [WIDTH-1:0]  input2,
  output logic [4:0]        shiftValue,
  input  logic [WIDTH-1:0]  result,
  input  logic              carryFlag,
  input  logic              zeroFlag,
  input  logic              overFlowFlag,
  output logic [CNT_W-1:0]  op_count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned WW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [WW-1:0] WAIT_INIT = WW'(SETTLE - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  typedef struct packed {
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [4:0]       sh;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  cmd_t             mem [DEPTH];
  cmd_t             head;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [1:0]       state;
  logic [WW-1:0]    wait_cnt;
  logic [TAG_W-1:0] cur_tag;
  logic             push;
  logic             pop;

  assign bus.cmd_ready = (count != FULL_CNT);
  assign push = bus.cmd_valid && bus.cmd_ready;
  assign pop  = (state == S_IDLE) && (count != '0);
  assign head = mem[rd_ptr];

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.cmd_opcode, bus.cmd_a, bus.cmd_b, bus.cmd_shift, bus.cmd_tag};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      state          <= S_IDLE;
      wait_cnt       <= '0;
      cur_tag        <= '0;
      opcode         <= '0;
      input1         <= '0;
      input2         <= '0;
      shiftValue     <= '0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_result <= '0;
      bus.rsp_flags  <= '0;
      bus.rsp_tag    <= '0;
`ifdef ALU_ZCHECK_EN
      bus.rsp_err    <= 1'b0;
`endif
      op_count       <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase

      case (state)
        S_IDLE: begin
          if (pop) begin
            opcode     <= head.op;
            input1     <= head.a;
            input2     <= head.b;
            shiftValue <= head.sh;
            cur_tag    <= head.tag;
            wait_cnt   <= WAIT_INIT;
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_cnt == '0) begin
            bus.rsp_result <= result;
            bus.rsp_flags  <= {overFlowFlag, zeroFlag, carryFlag};
            bus.rsp_tag    <= cur_tag;
`ifdef ALU_ZCHECK_EN
            bus.rsp_err    <= (zeroFlag != (result == '0));
`endif
            bus.rsp_valid  <= 1'b1;
            state          <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            op_count      <= op_count + 1'b1;
            state         <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_op_issuer.sv
// Bench for alu_op_issuer: u0 (SETTLE=1, CNT_W=3) and u1 (SETTLE=3), each with a small ALU model.
module tb_alu_op_issuer;
  localparam int unsigned W  = 16;
  localparam int unsigned TW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_op_issuer_if #(.WIDTH(W), .TAG_W(TW)) b0 ();
  alu_op_issuer_if #(.WIDTH(W), .TAG_W(TW)) b1 ();

  logic [3:0]   op0, op1;
  logic [W-1:0] in1_0, in2_0, in1_1, in2_1, res0, res1;
  logic [4:0]   sh0, sh1;
  logic         c0, z0, v0, c1, z1, v1;
  logic [2:0]   cnt0;
  logic [15:0]  cnt1;
  logic         force_bad = 1'b0;

  // Attached ALU: returns {overflow, zero, carry, result}.
  function automatic logic [18:0] alu_f(input logic [3:0] op, input logic [15:0] a,
                                        input logic [15:0] b, input logic [4:0] sh);
    logic [16:0] wide;
    logic [15:0] r;
    logic        c, v;
    wide = '0; r = '0; c = 1'b0; v = 1'b0;
    case (op)
      4'd0: begin wide = {1'b0, a} + {1'b0, b}; r = wide[15:0]; c = wide[16];
                  v = (a[15] == b[15]) && (r[15] != a[15]); end
      4'd1: begin wide = {1'b0, a} - {1'b0, b}; r = wide[15:0]; c = wide[16];
                  v = (a[15] != b[15]) && (r[15] != a[15]); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = a << sh;
      4'd6: r = a >> sh;
      default: r = a + b + 16'(op);
    endcase
    return {v, (r == 16'h0000), c, r};
  endfunction

  always_comb begin
    {v0, z0, c0, res0} = alu_f(op0, in1_0, in2_0, sh0);
    if (force_bad) begin
      res0 = '0;
      z0   = 1'b0;
    end
  end
  assign {v1, z1, c1, res1} = alu_f(op1, in1_1, in2_1, sh1);

  alu_op_issuer #(.WIDTH(W), .DEPTH(4), .SETTLE(1), .TAG_W(TW), .CNT_W(3)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(b0), .opcode(op0), .input1(in1_0), .input2(in2_0),
    .shiftValue(sh0), .result(res0), .carryFlag(c0), .zeroFlag(z0), .overFlowFlag(v0),
    .op_count(cnt0));

  alu_op_issuer #(.WIDTH(W), .DEPTH(4), .SETTLE(3), .TAG_W(TW), .CNT_W(16)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1), .opcode(op1), .input1(in1_1), .input2(in2_1),
    .shiftValue(sh1), .result(res1), .carryFlag(c1), .zeroFlag(z1), .overFlowFlag(v1),
    .op_count(cnt1));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout want handshake", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send0(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [4:0] sh, input logic [3:0] tag);
    int unsigned n;
    n = 0;
    b0.cmd_valid = 1'b1; b0.cmd_opcode = op; b0.cmd_a = a; b0.cmd_b = b;
    b0.cmd_shift = sh; b0.cmd_tag = tag;
    while (!b0.cmd_ready && n < 50) begin tick(); n++; end
    if (n >= 50) timeout("send0");
    tick();
    b0.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp0(output int unsigned cyc);
    cyc = 0;
    while (!b0.rsp_valid && cyc < 20) begin tick(); cyc++; end
    if (!b0.rsp_valid) timeout("wait_rsp0");
  endtask

  task automatic take_rsp0();
    b0.rsp_ready = 1'b1;
    tick();
    b0.rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [4:0]  sh;
    logic [3:0]  tag;
    logic [15:0] res;
    logic [2:0]  fl;
  } vec_t;

  typedef struct {
    logic [15:0] res;
    logic [2:0]  fl;
    logic [3:0]  tag;
  } exp_t;

  vec_t        vt [9];
  exp_t        q [$];
  exp_t        e;
  int unsigned ops0, cyc, acc, got, sent, rcvd;
  logic        took, rsp_hs, hold_prev, seen;
  logic [23:0] prev;
  logic [18:0] m;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{4'd0,  16'h7FFF, 16'h0001, 5'd0,  4'd3,  16'h8000, 3'b100};
    vt[1] = '{4'd1,  16'h0005, 16'h0007, 5'd0,  4'd1,  16'hFFFE, 3'b001};
    vt[2] = '{4'd0,  16'hFFFF, 16'h0001, 5'd0,  4'd2,  16'h0000, 3'b011};
    vt[3] = '{4'd2,  16'hF0F0, 16'h0FF0, 5'd0,  4'd4,  16'h00F0, 3'b000};
    vt[4] = '{4'd5,  16'h0001, 16'h0000, 5'd15, 4'd5,  16'h8000, 3'b000};
    vt[5] = '{4'd6,  16'h8000, 16'h0000, 5'd4,  4'd6,  16'h0800, 3'b000};
    vt[6] = '{4'd1,  16'h8000, 16'h0001, 5'd0,  4'd7,  16'h7FFF, 3'b100};
    vt[7] = '{4'd15, 16'h0010, 16'h0001, 5'd9,  4'd8,  16'h0020, 3'b000};
    vt[8] = '{4'd4,  16'h1234, 16'h1234, 5'd0,  4'd15, 16'h0000, 3'b010};

    b0.cmd_valid = 1'b0; b0.cmd_opcode = '0; b0.cmd_a = '0; b0.cmd_b = '0;
    b0.cmd_shift = '0; b0.cmd_tag = '0; b0.rsp_ready = 1'b0;
    b1.cmd_valid = 1'b0; b1.cmd_opcode = '0; b1.cmd_a = '0; b1.cmd_b = '0;
    b1.cmd_shift = '0; b1.cmd_tag = '0; b1.rsp_ready = 1'b0;
    ops0 = 0;

    tick(); tick();
    chk("rst_cmd_ready", b0.cmd_ready, 1'b1);
    chk("rst_rsp", {b0.rsp_valid, b0.rsp_result, b0.rsp_flags, b0.rsp_tag}, '0);
    chk("rst_drive", {op0, in1_0, in2_0, sh0}, '0);
    chk("rst_op_count", cnt0, 3'd0);
    rst_n = 1'b1;
    tick();

    // Table vectors: fixed latency, hand-computed results, drive registers, op_count wrap.
    for (int unsigned i = 0; i < 9; i++) begin
      send0(vt[i].op, vt[i].a, vt[i].b, vt[i].sh, vt[i].tag);
      wait_rsp0(cyc);
      chk("latency", cyc, 2);
      chk("rsp_fields", {b0.rsp_result, b0.rsp_flags, b0.rsp_tag}, {vt[i].res, vt[i].fl, vt[i].tag});
      chk("drive_regs", {op0, in1_0, in2_0, sh0}, {vt[i].op, vt[i].a, vt[i].b, vt[i].sh});
      take_rsp0();
      ops0++;
      chk("rsp_valid_clr", b0.rsp_valid, 1'b0);
      chk("op_count", cnt0, 3'(ops0));
    end
    chk("op_count_wrap", cnt0, 3'd1);

    // Response backpressure: everything held for 10 cycles.
    send0(4'd1, 16'h0005, 16'h0007, 5'd0, 4'd7);
    wait_rsp0(cyc);
    for (int unsigned k = 0; k < 10; k++) begin
      chk("bp_hold", {b0.rsp_valid, b0.rsp_result, b0.rsp_flags, b0.rsp_tag, op0, in1_0, in2_0},
          {1'b1, 16'hFFFE, 3'b001, 4'd7, 4'd1, 16'h0005, 16'h0007});
      tick();
    end
    take_rsp0();
    ops0++;
    chk("bp_op_count", cnt0, 3'(ops0));

    // Fill: 1 in flight + 4 queued, then drain in order while tag 5 waits for space.
    acc = 0;
    b0.cmd_valid = 1'b1; b0.cmd_opcode = 4'd0; b0.cmd_b = 16'h0001; b0.cmd_shift = '0;
    b0.cmd_tag = '0; b0.cmd_a = '0;
    for (int unsigned k = 0; k < 12 && b0.cmd_ready; k++) begin
      tick();
      acc++;
      b0.cmd_tag = 4'(acc);
      b0.cmd_a = 16'(acc * 32'h1111);
    end
    chk("full_accepts", acc, 5);
    tick(); tick(); tick();
    chk("full_cmd_ready", b0.cmd_ready, 1'b0);
    b0.rsp_ready = 1'b1;
    got = 0;
    for (int unsigned k = 0; k < 80 && got < 6; k++) begin
      took = b0.cmd_valid && b0.cmd_ready;
      if (b0.rsp_valid) begin
        m = alu_f(4'd0, 16'(got * 32'h1111), 16'h0001, 5'd0);
        chk("order", {b0.rsp_tag, b0.rsp_result, b0.rsp_flags}, {4'(got), m[15:0], m[18:16]});
        got++;
        ops0++;
      end
      tick();
      if (took) begin b0.cmd_valid = 1'b0; acc++; end
    end
    b0.rsp_ready = 1'b0;
    if (got < 6) timeout("order_drain");
    chk("tag5_accepted", acc, 6);
    chk("order_op_count", cnt0, 3'(ops0));

`ifdef ALU_ZCHECK_EN
    force_bad = 1'b1;
    send0(4'd0, 16'h0003, 16'h0004, 5'd0, 4'd2);
    wait_rsp0(cyc);
    chk("rsp_err_set", {b0.rsp_err, b0.rsp_result, b0.rsp_flags[1]}, {1'b1, 16'h0000, 1'b0});
    force_bad = 1'b0;
    take_rsp0();
    ops0++;
    send0(4'd0, 16'h0000, 16'h0000, 5'd0, 4'd3);
    wait_rsp0(cyc);
    chk("rsp_err_clr", {b0.rsp_err, b0.rsp_result, b0.rsp_flags[1]}, {1'b0, 16'h0000, 1'b1});
    take_rsp0();
    ops0++;
    chk("zchk_op_count", cnt0, 3'(ops0));
`endif

    // Random traffic against a scoreboard of expected responses.
    sent = 0; rcvd = 0; hold_prev = 1'b0; prev = '0;
    for (int unsigned k = 0; k < 3000 && rcvd < 40; k++) begin
      if (!b0.cmd_valid && sent < 40 && $urandom_range(0, 1) == 1) begin
        b0.cmd_opcode = 4'($urandom_range(0, 15));
        b0.cmd_a      = 16'($urandom);
        b0.cmd_b      = 16'($urandom);
        b0.cmd_shift  = 5'($urandom);
        b0.cmd_tag    = 4'($urandom);
        b0.cmd_valid  = 1'b1;
      end
      b0.rsp_ready = ($urandom_range(0, 3) != 0);
      if (hold_prev)
        chk("rand_hold", {b0.rsp_valid, b0.rsp_result, b0.rsp_flags, b0.rsp_tag}, prev);
      hold_prev = b0.rsp_valid && !b0.rsp_ready;
      prev = {b0.rsp_valid, b0.rsp_result, b0.rsp_flags, b0.rsp_tag};
      took = b0.cmd_valid && b0.cmd_ready;
      if (took) begin
        m = alu_f(b0.cmd_opcode, b0.cmd_a, b0.cmd_b, b0.cmd_shift);
        q.push_back('{m[15:0], m[18:16], b0.cmd_tag});
        sent++;
      end
      rsp_hs = b0.rsp_valid && b0.rsp_ready;
      if (rsp_hs) begin
        if (q.size() == 0) begin
          timeout("rand_unexpected_rsp");
        end else begin
          e = q.pop_front();
          chk("rand_rsp", {b0.rsp_result, b0.rsp_flags, b0.rsp_tag}, {e.res, e.fl, e.tag});
        end
        rcvd++;
        ops0++;
      end
      tick();
      if (took) b0.cmd_valid = 1'b0;
      if (rsp_hs) chk("rand_op_count", cnt0, 3'(ops0));
    end
    b0.rsp_ready = 1'b0;
    chk("rand_done", {rcvd, sent}, {32'd40, 32'd40});

    // SETTLE=3 instance: latency, then reset while in WAIT with two commands queued.
    b1.cmd_valid = 1'b1; b1.cmd_opcode = 4'd0; b1.cmd_a = 16'h1234; b1.cmd_b = 16'h0001;
    b1.cmd_shift = 5'd3; b1.cmd_tag = 4'd9;
    tick();
    b1.cmd_valid = 1'b0;
    cyc = 0;
    while (!b1.rsp_valid && cyc < 20) begin tick(); cyc++; end
    chk("s3_latency", cyc, 4);
    chk("s3_rsp", {b1.rsp_result, b1.rsp_flags, b1.rsp_tag}, {16'h1235, 3'b000, 4'd9});
    b1.rsp_ready = 1'b1;
    tick();
    b1.rsp_ready = 1'b0;
    chk("s3_op_count", cnt1, 16'd1);

    b1.cmd_valid = 1'b1; b1.cmd_opcode = 4'd4; b1.cmd_a = 16'hA5A5; b1.cmd_b = 16'h0F0F;
    b1.cmd_shift = 5'd7; b1.cmd_tag = 4'd1;
    tick();
    b1.cmd_tag = 4'd2;
    tick();
    b1.cmd_tag = 4'd3;
    tick();
    b1.cmd_valid = 1'b0;
    chk("s3_wait_drive", {op1, in1_1, in2_1, sh1, b1.rsp_valid},
        {4'd4, 16'hA5A5, 16'h0F0F, 5'd7, 1'b0});
    rst_n = 1'b0;
    #1;
    chk("s3_rst_drive", {op1, in1_1, in2_1, sh1}, '0);
    chk("s3_rst_rsp", {b1.rsp_valid, b1.rsp_result, b1.rsp_flags, b1.rsp_tag}, '0);
    chk("s3_rst_misc", {b1.cmd_ready, cnt1}, {1'b1, 16'd0});
    tick(); tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int unsigned k = 0; k < 12; k++) begin
      tick();
      if (b1.rsp_valid) seen = 1'b1;
    end
    chk("s3_no_rsp", seen, 1'b0);
    chk("s3_post_rst", {b1.cmd_ready, op1, in1_1, in2_1, sh1, cnt1}, {1'b1, 57'd0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_op_issuer.md
Name: alu_op_issuer

Overview:
- Sequential driver for the team's combinational ALUs; it sits at the opposite end of the ALU port interface.
- Accepts operation commands through a valid/ready queue and drives opcode, input1, input2 and shiftValue into an attached ALU.
- Samples result and the three flags after a fixed settle time, then returns them with the command tag through a valid/ready response port.
- Used by test harnesses and by the datapath sequencer in front of every ALU variant.

Parameters:
- WIDTH, 16: operand and result width.
- DEPTH, 4: command FIFO entries; power of 2, at least 2.
- SETTLE, 1: cycles between driving the ALU inputs and sampling its outputs; at least 1.
- TAG_W, 4: command tag width.
- CNT_W, 16: width of the issued-operation counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high.
- cmd_opcode  in  4  ALU opcode.
- cmd_a  in  WIDTH  operand A.
- cmd_b  in  WIDTH  operand B.
- cmd_shift  in  5  shift amount.
- cmd_tag  in  TAG_W  returned unchanged with the response.
- opcode  out  4  to ALU opcode.
- input1  out  WIDTH  to ALU input1.
- input2  out  WIDTH  to ALU input2.
- shiftValue  out  5  to ALU shiftValue.
- result  in  WIDTH  from ALU.
- carryFlag  in  1  from ALU.
- zeroFlag  in  1  from ALU.
- overFlowFlag  in  1  from ALU.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid and rsp_ready are both high.
- rsp_result  out  WIDTH  captured result.
- rsp_flags  out  3  captured flags: bit 2 overFlowFlag, bit 1 zeroFlag, bit 0 carryFlag.
- rsp_tag  out  TAG_W  tag of the command that produced this response.
- op_count  out  CNT_W  count of completed responses, wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst_n low, takes effect immediately):
  - FIFO empty; state IDLE.
  - opcode, input1, input2, shiftValue, rsp_* and op_count all 0.
  - cmd_ready = 1.
- Command FIFO:
  - cmd_ready = !full, combinational from the occupancy count.
  - Push on accept; pop only in IDLE when not empty.
  - Simultaneous push and pop leaves occupancy unchanged.
  - No push when full; no pop when empty.
  - Pointers wrap modulo DEPTH.
- FSM states IDLE, WAIT, RESP:
  - IDLE: if FIFO is non-empty, pop the head entry, register opcode/input1/input2/shiftValue from it, latch the tag, set wait counter = SETTLE-1, go to WAIT. Otherwise stay in IDLE.
  - WAIT: if counter = 0, capture result and the flags into rsp_result/rsp_flags, set rsp_valid = 1, go to RESP. Otherwise decrement the counter.
  - RESP: on rsp_ready, clear rsp_valid, increment op_count, go to IDLE.
- Latency and throughput:
  - A command accepted at edge t into an empty FIFO with the FSM in IDLE is popped at edge t+1.
  - rsp_valid rises after edge t+1+SETTLE.
  - Minimum spacing between operations is SETTLE+2 cycles.
- Held values:
  - ALU-drive registers keep their last values between operations; they are not cleared.
  - rsp_* fields are stable while rsp_valid is high and rsp_ready is low.
  - The FIFO keeps accepting commands during response backpressure until full.
- No opcode filtering: opcodes 8–15 pass through unchanged, and the ALU's output is reported as-is.
- Responses return strictly in command order.
- Reset mid-operation: the in-flight operation and all queued commands are discarded, and no response is produced.

Optional Feature:
- Macro ALU_ZCHECK_EN.
- Defined:
  - Adds output port rsp_err (1 bit), reset 0.
  - rsp_err is captured with rsp_result and set to 1 when zeroFlag != (result == 0).
  - It follows the same hold rules as the other rsp_* fields.
  - op_count is unaffected.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset release, then ADD (opcode 0), a=0x7FFF, b=0x0001, tag 3, with an ALU model attached -> rsp_valid 2 cycles after accept; rsp_result 0x8000; rsp_flags 3'b100; rsp_tag 3; op_count 1.
- rsp_ready held 0; push 6 back-to-back commands with tags 0–5 -> cmd_ready drops after 5 accepts (1 in flight + 4 queued). Then rsp_ready=1 -> responses arrive with tags 0,1,2,3,4 in order; the tag-5 command is accepted as soon as space frees.
- Backpressure: rsp_ready held low for 10 cycles after a SUB with a=0x0005, b=0x0007 -> rsp_result 0xFFFE and rsp_flags stay constant throughout; opcode/input1/input2 stay 1/0x0005/0x0007.
- Assert rst_n low while in WAIT with SETTLE=3 and 2 commands queued -> all outputs 0 immediately; after release, no response appears and cmd_ready=1.
- CNT_W=3, run 9 operations -> op_count reads 1 after the ninth handshake.
- ALU_ZCHECK_EN defined; model forces result=0x0000 with zeroFlag=0 -> rsp_err=1. Next operation with a consistent model -> rsp_err=0.
